// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage pipeline register modes, PC hold,
// MDU occupancy sequencing and stall/flush event counters.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 8,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_is_load_i,
    input  logic                  ex_redirect_i,
    input  logic                  ex_mdu_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_stall_o,
    output logic [1:0]            if_id_mode_o,
    output logic [1:0]            id_ex_mode_o,
    output logic [1:0]            ex_mem_mode_o,
    output logic [1:0]            mem_wb_mode_o,
    output logic                  mdu_start_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o,
    output logic [1:0]            fsm_state_o
);

    localparam int CNT_W = $clog2(MDU_LATENCY);

    localparam logic [1:0] MODE_PASS  = 2'b00;
    localparam logic [1:0] MODE_FLUSH = 2'b01;
    localparam logic [1:0] MODE_STALL = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memwait;
    logic              lu;
    logic              mdustall;
    logic              flush_evt;

    // Data memory handshake: a MEM-stage access (dmem_req_i) completes on the
    // cycle dmem_ready_i is high; every cycle with req high and ready low is a wait.
    assign memwait = dmem_req_i & ~dmem_ready_i;

    assign lu = ex_is_load_i && (ex_rd_i != '0) &&
                ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                 (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    assign mdustall = ((state_q == ST_RUN) && ex_mdu_i) ||
                      ((state_q == ST_BUSY) && (cnt_q != '0));

    assign fsm_state_o = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_stall_o) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_evt)  flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end

    // MDU sequencing; cnt keeps counting through memory waits since the MDU
    // runs on its own once started.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_start_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_mdu_i && !memwait) begin
                    mdu_start_o = 1'b1;
                    cnt_d       = CNT_W'(MDU_LATENCY - 2);
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
                else if (memwait) state_d = ST_HOLD;
                else              state_d = ST_RUN;
            end
            ST_HOLD: begin
                if (!memwait) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (rst_i) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            mdu_start_o = 1'b0;
        end
    end

    always_comb begin
        pc_stall_o    = 1'b0;
        if_id_mode_o  = MODE_PASS;
        id_ex_mode_o  = MODE_PASS;
        ex_mem_mode_o = MODE_PASS;
        mem_wb_mode_o = MODE_PASS;
        flush_evt     = 1'b0;
        if (rst_i) begin
            if_id_mode_o  = MODE_FLUSH;
            id_ex_mode_o  = MODE_FLUSH;
            ex_mem_mode_o = MODE_FLUSH;
            mem_wb_mode_o = MODE_FLUSH;
        end else if (memwait) begin
            pc_stall_o    = 1'b1;
            if_id_mode_o  = MODE_STALL;
            id_ex_mode_o  = MODE_STALL;
            ex_mem_mode_o = MODE_STALL;
            mem_wb_mode_o = MODE_FLUSH;
        end else if (mdustall) begin
            pc_stall_o    = 1'b1;
            if_id_mode_o  = MODE_STALL;
            id_ex_mode_o  = MODE_STALL;
            ex_mem_mode_o = MODE_FLUSH;
        end else if (ex_redirect_i) begin
            if_id_mode_o  = MODE_FLUSH;
            id_ex_mode_o  = MODE_FLUSH;
            flush_evt     = 1'b1;
        end else if (lu) begin
            pc_stall_o    = 1'b1;
            if_id_mode_o  = MODE_STALL;
            id_ex_mode_o  = MODE_FLUSH;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MDU_LATENCY = 4; hand-computed
// expectations checked by immediate assertions.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used;
    logic        ex_is_load, ex_redirect, ex_mdu;
    logic        dmem_req, dmem_ready;
    logic        pc_stall, mdu_start;
    logic [1:0]  if_id_mode, id_ex_mode, ex_mem_mode, mem_wb_mode, fsm_state;
    logic [31:0] stall_cnt, flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    hazard_ctrl #(.MDU_LATENCY(4), .REG_ADDR_W(5)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rs1_used_i (id_rs1_used),
        .id_rs2_used_i (id_rs2_used),
        .ex_rd_i       (ex_rd),
        .ex_is_load_i  (ex_is_load),
        .ex_redirect_i (ex_redirect),
        .ex_mdu_i      (ex_mdu),
        .dmem_req_i    (dmem_req),
        .dmem_ready_i  (dmem_ready),
        .pc_stall_o    (pc_stall),
        .if_id_mode_o  (if_id_mode),
        .id_ex_mode_o  (id_ex_mode),
        .ex_mem_mode_o (ex_mem_mode),
        .mem_wb_mode_o (mem_wb_mode),
        .mdu_start_o   (mdu_start),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt),
        .fsm_state_o   (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_is_load = 1'b0; ex_redirect = 1'b0; ex_mdu = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_modes(input string tag, input logic [7:0] exp, input logic exp_stall);
        #1;
        check({tag, ".modes"}, {24'd0, if_id_mode, id_ex_mode, ex_mem_mode, mem_wb_mode}, {24'd0, exp});
        check({tag, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, exp_stall});
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // reset: two cycles, modes 01, counters 0
        for (int i = 0; i < 2; i++) begin
            check_modes("rst", 8'b01_01_01_01, 1'b0);
            check("rst.start", {31'd0, mdu_start}, 32'd0);
            tick();
        end
        check("rst.stall_cnt", stall_cnt, 32'd0);
        check("rst.flush_cnt", flush_cnt, 32'd0);
        check("rst.state", {30'd0, fsm_state}, 32'd0);
        rst = 1'b0;
        check_modes("idle", 8'b00_00_00_00, 1'b0);
        tick();

        // load-use on rs1
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        check_modes("lu.rs1", 8'b10_01_00_00, 1'b1);
        tick();
        idle();
        check_modes("lu.after", 8'b00_00_00_00, 1'b0);
        check("lu.stall_cnt", stall_cnt, 32'd1);

        // load to x0 never stalls
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
        check_modes("lu.x0", 8'b00_00_00_00, 1'b0);
        tick();
        // rs2 matches but is not read
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_rs2_used = 1'b0;
        check_modes("lu.rs2_unused", 8'b00_00_00_00, 1'b0);
        id_rs2_used = 1'b1;
        check_modes("lu.rs2", 8'b10_01_00_00, 1'b1);
        tick();
        idle();
        check("lu.stall_cnt2", stall_cnt, 32'd2);

        // redirect beats load-use
        ex_redirect = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
        check_modes("redir_lu", 8'b01_01_00_00, 1'b0);
        tick();
        idle();
        check("redir.flush_cnt", flush_cnt, 32'd1);
        check("redir.stall_cnt", stall_cnt, 32'd2);

        // MDU, latency 4, ex_mdu held
        ex_mdu = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_modes($sformatf("mdu.c%0d", c), 8'b10_10_01_00, 1'b1);
            check($sformatf("mdu.start.c%0d", c), {31'd0, mdu_start}, (c == 0) ? 32'd1 : 32'd0);
            tick();
        end
        check_modes("mdu.c3", 8'b00_00_00_00, 1'b0);
        check("mdu.start.c3", {31'd0, mdu_start}, 32'd0);
        tick();
        ex_mdu = 1'b0;
        check("mdu.state", {30'd0, fsm_state}, 32'd0);
        check("mdu.stall_cnt", stall_cnt, 32'd5);

        // MDU with memwait from BUSY cnt = 1 for 3 cycles
        ex_mdu = 1'b1;
        #1;
        check("mw.start", {31'd0, mdu_start}, 32'd1);
        tick();
        check("mw.busy", {30'd0, fsm_state}, 32'd1);
        tick();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_modes($sformatf("mw.wait%0d", c), 8'b10_10_10_01, 1'b1);
            tick();
            if (c == 1) check("mw.hold", {30'd0, fsm_state}, 32'd2);
        end
        dmem_ready = 1'b1;
        check_modes("mw.release", 8'b00_00_00_00, 1'b0);
        check("mw.no_restart", {31'd0, mdu_start}, 32'd0);
        tick();
        idle();
        check("mw.state", {30'd0, fsm_state}, 32'd0);
        check("mw.stall_cnt", stall_cnt, 32'd10);

        // memwait masks redirect
        ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_modes($sformatf("mwr.wait%0d", c), 8'b10_10_10_01, 1'b1);
            tick();
        end
        dmem_ready = 1'b1;
        check_modes("mwr.release", 8'b01_01_00_00, 1'b0);
        check("mwr.flush_cnt", flush_cnt, 32'd1);
        check("mwr.stall_cnt", stall_cnt, 32'd13);
        tick();
        idle();
        check("mwr.flush_cnt2", flush_cnt, 32'd2);

        // mid-operation reset aborts the MDU
        ex_mdu = 1'b1;
        tick();
        rst = 1'b1;
        check_modes("abort.rst", 8'b01_01_01_01, 1'b0);
        tick();
        rst = 1'b0;
        ex_mdu = 1'b0;
        check("abort.state", {30'd0, fsm_state}, 32'd0);
        check("abort.stall_cnt", stall_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central pipeline hazard controller for the five-stage core. It drives the per-stage `mode` buses of the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC hold, based on four conditions:
- load-use dependences
- EX-stage control redirects
- data-memory wait states
- multi-cycle MDU operations

MDU occupancy is sequenced internally by a small FSM and down-counter, so the MDU needs no separate done handshake. The block also keeps stall and flush event counters for performance analysis.

## Interface
Parameters:
- `MDU_LATENCY`, default 8: total cycles an MDU instruction occupies EX. Must be ≥ 2.
- `REG_ADDR_W`, default 5: register-address width.

Ports:
- `clk_i` in 1: clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `id_rs1_i`, `id_rs2_i` in `REG_ADDR_W`: source registers of the instruction in ID.
- `id_rs1_used_i`, `id_rs2_used_i` in 1: the ID instruction reads rs1/rs2.
- `ex_rd_i` in `REG_ADDR_W`: destination register of the instruction in EX.
- `ex_is_load_i` in 1: the EX instruction is a load.
- `ex_redirect_i` in 1: branch taken or jump resolved in EX.
- `ex_mdu_i` in 1: the EX instruction is mul/div.
- `dmem_req_i`, `dmem_ready_i` in 1: MEM-stage data request and ready.
- `pc_stall_o` out 1: hold the PC.
- `if_id_mode_o`, `id_ex_mode_o`, `ex_mem_mode_o`, `mem_wb_mode_o` out 2: pipeline register control.
  - Bit 0 = flush, bit 1 = stall.
  - Encodings are 00 pass, 01 flush, 10 stall; 11 is never driven.
- `mdu_start_o` out 1: one-cycle start pulse to the MDU.
- `stall_cnt_o` out 32: cycles with `pc_stall_o` = 1.
- `flush_cnt_o` out 32: cycles with a redirect flush.

## Operation
Derived conditions (combinational):
- `memwait` = `dmem_req_i` & ~`dmem_ready_i`.
- `lu` = `ex_is_load_i` & (`ex_rd_i` ≠ 0) & ((`id_rs1_used_i` & `id_rs1_i` == `ex_rd_i`) | (`id_rs2_used_i` & `id_rs2_i` == `ex_rd_i`)).
- `mdustall` = (state RUN & `ex_mdu_i`) | (state BUSY & cnt ≠ 0).

Output actions, first matching row wins:
1. `rst_i`: `pc_stall_o` = 0; all four modes 01; `mdu_start_o` = 0.
2. `memwait`: `pc_stall_o` = 1; IF/ID, ID/EX and EX/MEM = 10; MEM/WB = 01. `ex_redirect_i` and `lu` are ignored.
3. `mdustall`: `pc_stall_o` = 1; IF/ID and ID/EX = 10; EX/MEM = 01; MEM/WB = 00.
4. `ex_redirect_i`: `pc_stall_o` = 0; IF/ID and ID/EX = 01; others 00.
5. `lu`: `pc_stall_o` = 1; IF/ID = 10; ID/EX = 01; others 00.
6. Otherwise: all modes 00 and `pc_stall_o` = 0.

FSM states: RUN, BUSY, HOLD. Reset state is RUN, cnt = 0. cnt width is clog2(`MDU_LATENCY`).
- **RUN**:
  - If `ex_mdu_i` & ~`memwait`: `mdu_start_o` = 1, cnt ← `MDU_LATENCY`−2, go to BUSY.
  - If `ex_mdu_i` & `memwait`: no start; stay in RUN.
- **BUSY**:
  - cnt ≠ 0: cnt ← cnt−1 every cycle, including cycles with `memwait` (the MDU runs independently).
  - cnt == 0 & ~`memwait`: no MDU stall (the EX instruction advances), go to RUN.
  - cnt == 0 & `memwait`: go to HOLD.
- **HOLD**: no MDU stall is generated; outputs follow `memwait`. On the first cycle with ~`memwait`, go to RUN.
  - That release cycle passes the MDU instruction through even though `ex_mdu_i` = 1, so it is not restarted.
- `rst_i` in any state forces RUN and cnt = 0 on the next edge. An aborted MDU operation is discarded.

Counters:
- `stall_cnt_o` increments on every non-reset cycle with `pc_stall_o` = 1.
- `flush_cnt_o` increments on every cycle where row 4 applies.
- Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by `rst_i`.

## Timing
- Mode outputs, `pc_stall_o` and `mdu_start_o` are combinational from the current state and inputs, so they act on the same clock edge as the pipeline registers.
- State, cnt and the counters are registered. Counter values reflect events up to the previous edge.
- Reset values: cnt = 0; `stall_cnt_o` = `flush_cnt_o` = 0; mode outputs 01 while `rst_i` is high.
- MDU instruction, no `memwait`: EX occupancy is exactly `MDU_LATENCY` cycles, of which the first `MDU_LATENCY`−1 assert `pc_stall_o`.
- Load-use costs exactly one bubble. The next cycle the load is in MEM and `lu` drops.
- Redirect costs two flushed slots (IF/ID, ID/EX) and no stall.

## Test plan
- Reset: hold `rst_i` for 2 cycles → all modes 01, `pc_stall_o` = 0, counters 0. After release with idle inputs → all modes 00.
- Load-use: `ex_is_load_i` = 1, `ex_rd_i` = 5, `id_rs1_i` = 5, `id_rs1_used_i` = 1 → one cycle of `pc_stall_o` = 1, IF/ID = 10, ID/EX = 01, `stall_cnt_o` = 1. Repeat with `ex_rd_i` = 0 → no stall.
- Redirect plus load-use in the same cycle → IF/ID = 01, ID/EX = 01, `pc_stall_o` = 0, `flush_cnt_o` = 1.
- `MDU_LATENCY` = 4 with `ex_mdu_i` held:
  - cycle 0 → `mdu_start_o` = 1;
  - cycles 0–2 → `pc_stall_o` = 1, EX/MEM = 01;
  - cycle 3 → all modes 00, FSM returns to RUN;
  - `stall_cnt_o` = 3.
- `memwait` rises at BUSY cnt = 1 and stays 3 cycles → FSM goes to HOLD with EX/MEM = 10 and MEM/WB = 01 throughout. The first ready cycle → modes 00, no second `mdu_start_o`.
- `memwait` for 3 cycles with `ex_redirect_i` = 1 → redirect ignored (`flush_cnt_o` unchanged); `stall_cnt_o` +3. The cycle after ready → IF/ID and ID/EX = 01.
